// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: opcode encodings,
// LSU state encodings, bus types and opcode decode helpers.
package mem_lsu_pkg;

   localparam int REG_W      = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [REG_W-1:0]      ZERO_WORD    = '0;
   localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

   typedef logic [3:0] mem_op_bus_t;
   typedef logic [7:0] byte_bus_t;

   localparam mem_op_bus_t MEM_NOP = 4'd0;
   localparam mem_op_bus_t MEM_LB  = 4'd1;
   localparam mem_op_bus_t MEM_LH  = 4'd2;
   localparam mem_op_bus_t MEM_LW  = 4'd3;
   localparam mem_op_bus_t MEM_LBU = 4'd4;
   localparam mem_op_bus_t MEM_LHU = 4'd5;
   localparam mem_op_bus_t MEM_SB  = 4'd6;
   localparam mem_op_bus_t MEM_SH  = 4'd7;
   localparam mem_op_bus_t MEM_SW  = 4'd8;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_READ,
      LSU_STORE,
      LSU_DONE
   } lsu_state_e;

   function automatic logic is_load(input mem_op_bus_t op);
      return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
   endfunction

   function automatic logic is_store(input mem_op_bus_t op);
      return op inside {MEM_SB, MEM_SH, MEM_SW};
   endfunction

   // Index of the last byte of the access, i.e. access size minus one.
   function automatic logic [1:0] last_byte(input mem_op_bus_t op);
      case (op)
         MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
         MEM_LW, MEM_SW:          return 2'd3;
         default:                 return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-result formatter: sign- or zero-extends the assembled
// load buffer according to the load opcode.
module lsu_load_ext
   import mem_lsu_pkg::*;
(
   input  logic [REG_W-1:0] load_buf,
   input  mem_op_bus_t      mem_op,
   output logic [REG_W-1:0] result
);

   always_comb begin
      result = load_buf;
      case (mem_op)
         MEM_LB:  result = {{24{load_buf[7]}}, load_buf[7:0]};
         MEM_LBU: result = {24'h000000, load_buf[7:0]};
         MEM_LH:  result = {{16{load_buf[15]}}, load_buf[15:0]};
         MEM_LHU: result = {16'h0000, load_buf[15:0]};
         default: result = load_buf;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: byte-serial access to an 8-bit synchronous RAM,
// stalling the pipeline until each load or store completes.
// Optional macro MEM_MISALIGN_CHK_EN rejects misaligned halfword/word accesses.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] ex_wd,
   input  logic                  ex_wreg,
   input  logic [REG_W-1:0]      ex_wdata,
   input  mem_op_bus_t           ex_mem_op,
   input  logic [ADDR_W-1:0]     ex_mem_addr,
   input  logic [REG_W-1:0]      ex_mem_sdata,
   output logic [REG_ADDR_W-1:0] wb_wd,
   output logic                  wb_wreg,
   output logic [REG_W-1:0]      wb_wdata,
   output logic                  stall_req,
   output logic                  misalign,
   output logic [ADDR_W-1:0]     ram_addr,
   output byte_bus_t             ram_dout,
   output logic                  ram_we,
   input  byte_bus_t             ram_din
);

   lsu_state_e       state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [REG_W-1:0] load_buf_q, load_buf_d;
   logic [REG_W-1:0] load_result;
   logic [1:0]       last;
   logic             op_load;
   logic             op_store;
   logic             misalign_hit;

   assign last     = last_byte(ex_mem_op);
   assign op_load  = is_load(ex_mem_op);
   assign op_store = is_store(ex_mem_op);

`ifdef MEM_MISALIGN_CHK_EN
   assign misalign_hit = (op_load || op_store) &&
                         (((last == 2'd1) && ex_mem_addr[0]) ||
                          ((last == 2'd3) && (ex_mem_addr[1:0] != 2'b00)));
`else
   assign misalign_hit = 1'b0;
`endif

   lsu_load_ext u_load_ext (
      .load_buf (load_buf_q),
      .mem_op   (ex_mem_op),
      .result   (load_result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LSU_IDLE;
         cnt_q      <= 2'd0;
         load_buf_q <= ZERO_WORD;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         load_buf_q <= load_buf_d;
      end
   end

   // Loads present the next address while capturing the byte addressed in the
   // previous cycle; stores write one byte per cycle starting in IDLE itself.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      load_buf_d = load_buf_q;
      wb_wd      = NOP_REG_ADDR;
      wb_wreg    = 1'b0;
      wb_wdata   = ZERO_WORD;
      stall_req  = 1'b0;
      misalign   = 1'b0;
      ram_addr   = '0;
      ram_dout   = 8'h00;
      ram_we     = 1'b0;

      case (state_q)
         LSU_IDLE: begin
            if (misalign_hit) begin
               misalign = 1'b1;
               wb_wd    = ex_wd;
               wb_wdata = ex_wdata;
            end else if (op_load) begin
               ram_addr  = ex_mem_addr;
               stall_req = 1'b1;
               cnt_d     = 2'd0;
               state_d   = LSU_READ;
            end else if (op_store) begin
               ram_addr  = ex_mem_addr;
               ram_dout  = ex_mem_sdata[7:0];
               ram_we    = 1'b1;
               stall_req = 1'b1;
               if (last != 2'd0) begin
                  cnt_d   = 2'd1;
                  state_d = LSU_STORE;
               end else begin
                  state_d = LSU_DONE;
               end
            end else begin
               wb_wd    = ex_wd;
               wb_wreg  = ex_wreg;
               wb_wdata = ex_wdata;
            end
         end

         LSU_READ: begin
            stall_req = 1'b1;
            load_buf_d[{cnt_q, 3'b000} +: 8] = ram_din;
            if (cnt_q < last) begin
               ram_addr = ex_mem_addr + ADDR_W'(cnt_q) + ADDR_W'(1);
               cnt_d    = cnt_q + 2'd1;
            end else begin
               state_d = LSU_DONE;
            end
         end

         LSU_STORE: begin
            ram_addr  = ex_mem_addr + ADDR_W'(cnt_q);
            ram_dout  = ex_mem_sdata[{cnt_q, 3'b000} +: 8];
            ram_we    = 1'b1;
            stall_req = 1'b1;
            if (cnt_q == last) begin
               state_d = LSU_DONE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end

         LSU_DONE: begin
            wb_wd    = ex_wd;
            wb_wreg  = ex_wreg;
            wb_wdata = op_load ? load_result : ex_wdata;
            cnt_d    = 2'd0;
            state_d  = LSU_IDLE;
         end

         default: state_d = LSU_IDLE;
      endcase

      // Reset forces the whole output bus quiet, which also blocks any
      // further RAM writes from an abandoned store.
      if (rst) begin
         wb_wd     = NOP_REG_ADDR;
         wb_wreg   = 1'b0;
         wb_wdata  = ZERO_WORD;
         stall_req = 1'b0;
         misalign  = 1'b0;
         ram_addr  = '0;
         ram_dout  = 8'h00;
         ram_we    = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a byte-wide synchronous RAM model.
// Honours MEM_MISALIGN_CHK_EN to pick the expected misaligned-access behaviour.
module tb_mem_lsu;
   import mem_lsu_pkg::*;

   logic        clk;
   logic        rst;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic [3:0]  ex_mem_op;
   logic [31:0] ex_mem_addr;
   logic [31:0] ex_mem_sdata;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata;
   logic        stall_req;
   logic        misalign;
   logic [31:0] ram_addr;
   logic [7:0]  ram_dout;
   logic        ram_we;
   logic [7:0]  ram_din;

   int checks;
   int failures;
   int cyc;

   logic [7:0]  mem [0:1023];
   logic [31:0] wl_addr [$];
   logic [7:0]  wl_data [$];
   int          wl_cyc  [$];

   mem_lsu #(.ADDR_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_wd        (ex_wd),
      .ex_wreg      (ex_wreg),
      .ex_wdata     (ex_wdata),
      .ex_mem_op    (ex_mem_op),
      .ex_mem_addr  (ex_mem_addr),
      .ex_mem_sdata (ex_mem_sdata),
      .wb_wd        (wb_wd),
      .wb_wreg      (wb_wreg),
      .wb_wdata     (wb_wdata),
      .stall_req    (stall_req),
      .misalign     (misalign),
      .ram_addr     (ram_addr),
      .ram_dout     (ram_dout),
      .ram_we       (ram_we),
      .ram_din      (ram_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous RAM: read data appears the cycle after the address; every write is logged.
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr[9:0]] <= ram_dout;
         wl_addr.push_back(ram_addr);
         wl_data.push_back(ram_dout);
         wl_cyc.push_back(cyc);
      end
      ram_din <= mem[ram_addr[9:0]];
   end

   task automatic clear_log();
      wl_addr.delete();
      wl_data.delete();
      wl_cyc.delete();
   endtask

   // Applies one op at the start of a cycle, counts stall cycles, and returns
   // the write-back bus seen in the first non-stalled cycle.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [31:0] wdata,
                                input logic [4:0] wd, input logic wreg,
                                output int stalls, output logic [31:0] r_wdata,
                                output logic [4:0] r_wd, output logic r_wreg,
                                output logic r_mis);
      ex_mem_op    = op;
      ex_mem_addr  = addr;
      ex_mem_sdata = sdata;
      ex_wdata     = wdata;
      ex_wd        = wd;
      ex_wreg      = wreg;
      stalls       = 0;
      @(negedge clk);
      while (stall_req !== 1'b0 && stalls < 20) begin
         stalls++;
         @(negedge clk);
      end
      r_wdata = wb_wdata;
      r_wd    = wb_wd;
      r_wreg  = wb_wreg;
      r_mis   = misalign;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ex_mem_op = MEM_NOP; ex_mem_addr = 32'h0000_0100; ex_mem_sdata = 32'hFFFF_FFFF;
      ex_wdata = 32'h1234_5678; ex_wd = 5'd7; ex_wreg = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (wb_wdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_wdata got=%h exp=00000000", wb_wdata); end
      checks++; if (wb_wd !== 5'd0 || wb_wreg !== 1'b0) begin failures++; $display("[TB] FAIL reset_wd_wreg got=%0d/%b exp=0/0", wb_wd, wb_wreg); end
      checks++; if (stall_req !== 1'b0 || ram_we !== 1'b0 || misalign !== 1'b0) begin failures++; $display("[TB] FAIL reset_ctrl got stall=%b we=%b mis=%b exp=0/0/0", stall_req, ram_we, misalign); end
      checks++; if (ram_addr !== 32'h0 || ram_dout !== 8'h0) begin failures++; $display("[TB] FAIL reset_ram_bus got addr=%h dout=%h exp=0/0", ram_addr, ram_dout); end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_passthrough();
      ex_mem_op = MEM_NOP; ex_wdata = 32'hDEAD_BEEF; ex_wd = 5'd5; ex_wreg = 1'b1;
      ex_mem_addr = 32'h0000_0040; ex_mem_sdata = 32'h5555_5555;
      #2;
      checks++; if (wb_wdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL pass_wdata got=%h exp=deadbeef", wb_wdata); end
      checks++; if (wb_wd !== 5'd5 || wb_wreg !== 1'b1) begin failures++; $display("[TB] FAIL pass_wd_wreg got=%0d/%b exp=5/1", wb_wd, wb_wreg); end
      checks++; if (stall_req !== 1'b0 || ram_we !== 1'b0) begin failures++; $display("[TB] FAIL pass_ctrl got stall=%b we=%b exp=0/0", stall_req, ram_we); end
      checks++; if (ram_addr !== 32'h0 || ram_dout !== 8'h0) begin failures++; $display("[TB] FAIL pass_ram_bus got addr=%h dout=%h exp=0/0", ram_addr, ram_dout); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_store_load_word();
      int st; logic [31:0] d; logic [4:0] w; logic r; logic m;
      clear_log();
      applyStimulus(MEM_SW, 32'h0000_0100, 32'h8433_2211, 32'h0000_0ABC, 5'd3, 1'b0, st, d, w, r, m);
      checks++; if (st != 4) begin failures++; $display("[TB] FAIL sw_stalls got=%0d exp=4", st); end
      checks++; if (wl_addr.size() != 4 || wl_addr[0] !== 32'h100 || wl_data[0] !== 8'h11 || wl_addr[3] !== 32'h103 || wl_data[3] !== 8'h84)
         begin failures++; $display("[TB] FAIL sw_writes got n=%0d exp n=4 [100]=11 [103]=84", wl_addr.size()); end
      checks++; if (d !== 32'h0000_0ABC || r !== 1'b0) begin failures++; $display("[TB] FAIL sw_wb got=%h/%b exp=00000abc/0", d, r); end
      applyStimulus(MEM_LW, 32'h0000_0100, 32'h0, 32'h0, 5'd9, 1'b1, st, d, w, r, m);
      checks++; if (st != 5) begin failures++; $display("[TB] FAIL lw_stalls got=%0d exp=5", st); end
      checks++; if (d !== 32'h8433_2211) begin failures++; $display("[TB] FAIL lw_data got=%h exp=84332211", d); end
      checks++; if (w !== 5'd9 || r !== 1'b1) begin failures++; $display("[TB] FAIL lw_wd_wreg got=%0d/%b exp=9/1", w, r); end
   endtask

   task automatic test_byte_half();
      int st; logic [31:0] d; logic [4:0] w; logic r; logic m;
      applyStimulus(MEM_SB, 32'h0000_0101, 32'hFFFF_FF80, 32'h0, 5'd0, 1'b0, st, d, w, r, m);
      checks++; if (st != 1) begin failures++; $display("[TB] FAIL sb_stalls got=%0d exp=1", st); end
      applyStimulus(MEM_LB, 32'h0000_0101, 32'h0, 32'h0, 5'd4, 1'b1, st, d, w, r, m);
      checks++; if (st != 2 || d !== 32'hFFFF_FF80) begin failures++; $display("[TB] FAIL lb_sign got=%h stalls=%0d exp=ffffff80 stalls=2", d, st); end
      applyStimulus(MEM_LBU, 32'h0000_0101, 32'h0, 32'h0, 5'd4, 1'b1, st, d, w, r, m);
      checks++; if (st != 2 || d !== 32'h0000_0080) begin failures++; $display("[TB] FAIL lbu_zero got=%h stalls=%0d exp=00000080 stalls=2", d, st); end
      applyStimulus(MEM_SH, 32'h0000_0104, 32'h0000_9000, 32'h0, 5'd0, 1'b0, st, d, w, r, m);
      applyStimulus(MEM_LH, 32'h0000_0104, 32'h0, 32'h0, 5'd6, 1'b1, st, d, w, r, m);
      checks++; if (st != 3 || d !== 32'hFFFF_9000) begin failures++; $display("[TB] FAIL lh_sign got=%h stalls=%0d exp=ffff9000 stalls=3", d, st); end
      applyStimulus(MEM_LHU, 32'h0000_0104, 32'h0, 32'h0, 5'd6, 1'b1, st, d, w, r, m);
      checks++; if (st != 3 || d !== 32'h0000_9000) begin failures++; $display("[TB] FAIL lhu_zero got=%h stalls=%0d exp=00009000 stalls=3", d, st); end
   endtask

   task automatic test_store_half();
      int st; logic [31:0] d; logic [4:0] w; logic r; logic m;
      clear_log();
      applyStimulus(MEM_SH, 32'h0000_0200, 32'hABCD_1234, 32'h0, 5'd0, 1'b0, st, d, w, r, m);
      checks++; if (st != 2) begin failures++; $display("[TB] FAIL sh_stalls got=%0d exp=2", st); end
      checks++; if (wl_addr.size() != 2) begin failures++; $display("[TB] FAIL sh_count got=%0d exp=2", wl_addr.size()); end
      else begin
         checks++; if (wl_addr[0] !== 32'h200 || wl_data[0] !== 8'h34 || wl_addr[1] !== 32'h201 || wl_data[1] !== 8'h12)
            begin failures++; $display("[TB] FAIL sh_bytes got %h:%h %h:%h exp 200:34 201:12", wl_addr[0], wl_data[0], wl_addr[1], wl_data[1]); end
         checks++; if (wl_cyc[1] != wl_cyc[0] + 1) begin failures++; $display("[TB] FAIL sh_consecutive got cycles %0d,%0d exp adjacent", wl_cyc[0], wl_cyc[1]); end
      end
   endtask

   task automatic test_reset_mid_store();
      int st; logic [31:0] d; logic [4:0] w; logic r; logic m;
      clear_log();
      ex_mem_op = MEM_SW; ex_mem_addr = 32'h0000_0300; ex_mem_sdata = 32'hA1B2_C3D4;
      ex_wdata = 32'h0; ex_wd = 5'd2; ex_wreg = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (stall_req !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 32'h0 || ram_dout !== 8'h0 || wb_wdata !== 32'h0)
         begin failures++; $display("[TB] FAIL midrst_outputs got stall=%b we=%b addr=%h dout=%h wdata=%h exp all 0", stall_req, ram_we, ram_addr, ram_dout, wb_wdata); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      ex_mem_op = MEM_NOP; ex_wdata = 32'hCAFE_F00D; ex_wd = 5'd1; ex_wreg = 1'b1;
      @(negedge clk);
      checks++; if (stall_req !== 1'b0 || wb_wdata !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL midrst_idle got stall=%b wdata=%h exp=0/cafef00d", stall_req, wb_wdata); end
      checks++; if (wl_addr.size() != 2 || wl_addr[0] !== 32'h300 || wl_data[0] !== 8'hD4 || wl_addr[1] !== 32'h301 || wl_data[1] !== 8'hC3)
         begin failures++; $display("[TB] FAIL midrst_writes got n=%0d exp n=2 [300]=d4 [301]=c3", wl_addr.size()); end
      @(posedge clk);
      #1;
      applyStimulus(MEM_LH, 32'h0000_0300, 32'h0, 32'h0, 5'd8, 1'b1, st, d, w, r, m);
      checks++; if (d !== 32'hFFFF_C3D4) begin failures++; $display("[TB] FAIL midrst_kept got=%h exp=ffffc3d4", d); end
   endtask

   task automatic test_back_to_back();
      int st; logic [31:0] d; logic [4:0] w; logic r; logic m;
      applyStimulus(MEM_SB, 32'h0000_0110, 32'h0000_005A, 32'h0, 5'd0, 1'b0, st, d, w, r, m);
      applyStimulus(MEM_LBU, 32'h0000_0110, 32'h0, 32'h0, 5'd11, 1'b1, st, d, w, r, m);
      checks++; if (st != 2 || d !== 32'h0000_005A || w !== 5'd11) begin failures++; $display("[TB] FAIL b2b_lbu got=%h wd=%0d stalls=%0d exp=0000005a wd=11 stalls=2", d, w, st); end
   endtask

   task automatic test_misalign();
      int st; logic [31:0] d; logic [4:0] w; logic r; logic m;
      clear_log();
`ifdef MEM_MISALIGN_CHK_EN
      applyStimulus(MEM_LW, 32'h0000_0102, 32'h0, 32'h0000_0777, 5'd12, 1'b1, st, d, w, r, m);
      checks++; if (m !== 1'b1 || r !== 1'b0 || st != 0) begin failures++; $display("[TB] FAIL mis_lw got mis=%b wreg=%b stalls=%0d exp=1/0/0", m, r, st); end
      applyStimulus(MEM_SH, 32'h0000_0121, 32'hFFFF_FFFF, 32'h0, 5'd0, 1'b0, st, d, w, r, m);
      checks++; if (m !== 1'b1 || st != 0 || wl_addr.size() != 0) begin failures++; $display("[TB] FAIL mis_sh got mis=%b stalls=%0d writes=%0d exp=1/0/0", m, st, wl_addr.size()); end
`else
      applyStimulus(MEM_LW, 32'h0000_0102, 32'h0, 32'h0, 5'd12, 1'b1, st, d, w, r, m);
      checks++; if (m !== 1'b0 || st != 5 || d !== 32'h9000_8433) begin failures++; $display("[TB] FAIL mis_lw got mis=%b stalls=%0d data=%h exp=0/5/90008433", m, st, d); end
      applyStimulus(MEM_SH, 32'hFFFF_FFFF, 32'h0000_BBAA, 32'h0, 5'd0, 1'b0, st, d, w, r, m);
      checks++; if (wl_addr.size() != 2 || wl_addr[0] !== 32'hFFFF_FFFF || wl_data[0] !== 8'hAA || wl_addr[1] !== 32'h0 || wl_data[1] !== 8'hBB)
         begin failures++; $display("[TB] FAIL wrap_sh got n=%0d exp n=2 [ffffffff]=aa [00000000]=bb", wl_addr.size()); end
`endif
   endtask

   // Drives every scenario in sequence and reports the totals.
   initial begin
      checks = 0;
      failures = 0;
      cyc = 0;
      test_reset();
      test_passthrough();
      test_store_load_word();
      test_byte_half();
      test_store_half();
      test_reset_mid_store();
      test_back_to_back();
      test_misalign();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
